// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, sync clear/load, terminal-count and compare flags.
// Define MOD_COUNTER_SAT_EN to build the saturating variant (holds at the bounds instead of wrapping).
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 255,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             match,
  output logic             at_zero,
  output logic             at_max
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             hit_max, hit_zero;

  assign tick     = en & (pre_q == PRE_LAST);
  assign hit_max  = (count_q == MAX_V);
  assign hit_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
      pre_d   = '0;
    end else if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
      pre_d   = '0;
    end else if (tick) begin
      pre_d = '0;
      if (up) begin
        if (hit_max) begin
          tc_d = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
          count_d = MAX_V;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (hit_zero) begin
          tc_d = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
          count_d = '0;
`else
          count_d = MAX_V;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign match   = (count_q == cmp_val);
  assign at_zero = hit_zero;
  assign at_max  = hit_max;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: two instances (PRESCALE 1 and 3) driven in lockstep against a behavioural model.
module tb_mod_counter;
  localparam int W = 4;
  localparam int M = 9;

  logic clk = 1'b0;
  logic rst, en, up, clr, load;
  logic [W-1:0] load_val, cmp_val;
  logic [W-1:0] cnt1, cnt3;
  logic tc1, tc3, mt1, mt3, z1, z3, mx1, mx3;

  int n_assert = 0;
  int n_fail   = 0;

  int pres [2] = '{1, 3};
  int m_cnt[2];
  int m_pre[2];
  bit m_tc [2];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(W), .MAX(M), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cmp_val(cmp_val),
    .count(cnt1), .tc(tc1), .match(mt1), .at_zero(z1), .at_max(mx1));

  mod_counter #(.WIDTH(W), .MAX(M), .PRESCALE(3)) u_p3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cmp_val(cmp_val),
    .count(cnt3), .tc(tc3), .match(mt3), .at_zero(z3), .at_max(mx3));

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a step is "count + or - 1 modulo (MAX+1)", or clamped in the saturating build.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_tc[k] = 1'b0;
      if (rst || clr) begin
        m_cnt[k] = 0; m_pre[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(load_val) > M) ? M : int'(load_val); m_pre[k] = 0;
      end else if (en) begin
        m_pre[k] = m_pre[k] + 1;
        if (m_pre[k] == pres[k]) begin
          int nxt;
          m_pre[k] = 0;
          nxt = m_cnt[k] + (up ? 1 : -1);
          if (nxt > M || nxt < 0) begin
            m_tc[k] = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
            nxt = m_cnt[k];
`else
            nxt = (nxt + M + 1) % (M + 1);
`endif
          end
          m_cnt[k] = nxt;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("p1.count", int'(cnt1), m_cnt[0]);
    chk("p1.tc",    int'(tc1),  int'(m_tc[0]));
    chk("p1.match", int'(mt1),  int'(m_cnt[0] == int'(cmp_val)));
    chk("p1.zero",  int'(z1),   int'(m_cnt[0] == 0));
    chk("p1.max",   int'(mx1),  int'(m_cnt[0] == M));
    chk("p3.count", int'(cnt3), m_cnt[1]);
    chk("p3.tc",    int'(tc3),  int'(m_tc[1]));
    chk("p3.match", int'(mt3),  int'(m_cnt[1] == int'(cmp_val)));
    chk("p3.zero",  int'(z3),   int'(m_cnt[1] == 0));
    chk("p3.max",   int'(mx3),  int'(m_cnt[1] == M));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  initial begin
    rst = 1; en = 0; up = 1; clr = 0; load = 0; load_val = '0; cmp_val = 4'd5;
    m_cnt = '{0, 0}; m_pre = '{0, 0}; m_tc = '{0, 0};
    cyc(2);
    chk("reset.count", int'(cnt1), 0);
    chk("reset.at_zero", int'(z1), 1);
    rst = 0;

    // Count up through a wrap, then down through the 0 boundary.
    en = 1; up = 1;
    cyc(12);
    rst = 1; cyc(1); rst = 0;
    up = 0;
    cyc(4);
`ifdef MOD_COUNTER_SAT_EN
    chk("down.sat.count", int'(cnt1), 0);
`else
    chk("down.wrap.count", int'(cnt1), 6);
`endif

    // Prescaler: stall en for 2 cycles mid-period.
    clr = 1; cyc(1); clr = 0; up = 1;
    cyc(4);
    en = 0; cyc(2); en = 1;
    cyc(7);

    // Load clamp, load+clr together, clr on a wrapping tick.
    load = 1; load_val = 4'd15; cyc(1); load = 0;
    chk("load.clamp", int'(cnt1), M);
    load = 1; clr = 1; cyc(1); load = 0; clr = 0;
    chk("load_clr.count", int'(cnt1), 0);
    load = 1; load_val = 4'd9; cyc(1); load = 0;
    clr = 1; cyc(1); clr = 0;
    chk("clr_on_wrap.tc", int'(tc1), 0);

    // rst mid-count at 7, prescaler restarts.
    cyc(7);
    rst = 1; cyc(1); rst = 0;
    cyc(8);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      up       = ($urandom_range(0, 15) != 0) ? up : ~up;
      clr      = ($urandom_range(0, 40) == 0);
      load     = ($urandom_range(0, 30) == 0);
      rst      = ($urandom_range(0, 80) == 0);
      load_val = W'($urandom_range(0, 15));
      cmp_val  = W'($urandom_range(0, 15));
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
